// File: rtl/md_pkg.sv
// Shared control encodings for the execute stage: ALU control and the
// multiply/divide unit operation select.
package md_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_ctr_e;

    // Encoding 7 is unused and decodes as MD_NONE.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

endpackage

// File: rtl/md_core.sv
// Combinational multiply/divide datapath: produces {hi,lo} for the
// operation selected by op; non-arithmetic ops yield zero.
module md_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]       prod;
    logic signed [WIDTH-1:0]  sa;
    logic signed [WIDTH-1:0]  sb;

    assign sa = a;
    assign sb = b;

    always_comb begin
        hi   = '0;
        lo   = '0;
        prod = '0;
        case (op)
            MD_MULT: begin
                // Sign-extend to full width; the low 2*WIDTH bits of the
                // unsigned product are then the signed product.
                prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
                {hi, lo} = prod;
            end
            MD_MULTU: begin
                prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                {hi, lo} = prod;
            end
            MD_DIV: begin
                if (b == '0) begin
                    lo = '1;
                    hi = a;
                end else if (a == MOST_NEG && b == '1) begin
                    lo = MOST_NEG;
                    hi = '0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            MD_DIVU: begin
                if (b == '0) begin
                    lo = '1;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: result is computed at accept, held in a
// latch register, and committed to HI/LO when the busy counter expires.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       MDctr,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [2*WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     core_hi, core_lo;
    logic                 accept;

    md_core #(.WIDTH(WIDTH)) u_core (
        .op (MDctr),
        .a  (DataA),
        .b  (DataB),
        .hi (core_hi),
        .lo (core_lo)
    );

    always_comb begin
        cnt_d  = cnt_q;
        res_d  = res_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        accept = Start && !Flush && !busy_q;

        // Commit on the edge where the counter reaches zero (Busy falls).
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                {hi_d, lo_d} = res_q;
            end
        end

        if (accept) begin
            case (MDctr)
                MD_MULT, MD_MULTU: begin
                    cnt_d = CW'(MUL_CYCLES);
                    res_d = {core_hi, core_lo};
                end
                MD_DIV, MD_DIVU: begin
                    cnt_d = CW'(DIV_CYCLES);
                    res_d = {core_hi, core_lo};
                end
                MD_MTHI: hi_d = DataA;
                MD_MTLO: lo_d = DataA;
                default: ;
            endcase
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            res_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            res_q  <= res_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width in bits.
REQ-002 SHALL have parameter MUL_CYCLES, default 5, busy duration of a multiply (legal range >= 1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, busy duration of a divide (legal range >= 1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MDctr  input  3  operation select: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is treated as NONE.
REQ-007 SHALL have port Start  input  1  qualifies MDctr for one cycle.
REQ-008 SHALL have port Flush  input  1  an exception is being taken this cycle; the current request is suppressed.
REQ-009 SHALL have port DataA  input  WIDTH  rs operand (multiplicand or dividend; the MTHI/MTLO source).
REQ-010 SHALL have port DataB  input  WIDTH  rt operand (multiplier or divisor).
REQ-011 SHALL have port Busy  output  1  registered; high while an operation is in flight.
REQ-012 SHALL have port HI  output  WIDTH  registered; the HI register.
REQ-013 SHALL have port LO  output  WIDTH  registered; the LO register.

Function
REQ-014 SHALL accept a request at an edge only when Start=1, Flush=0, Busy=0 and reset=0; otherwise SHALL ignore MDctr.
REQ-015 SHALL, on an accepted MULT/MULTU, latch the full 2*WIDTH product (signed or unsigned) and set Busy=1 for exactly MUL_CYCLES cycles.
REQ-016 SHALL, on an accepted DIV/DIVU, latch the quotient for LO and the remainder for HI (signed: truncate toward zero, remainder takes the dividend's sign), and set Busy=1 for exactly DIV_CYCLES cycles.
REQ-017 SHALL write {HI,LO} with the latched result at the edge on which Busy falls; HI/LO SHALL hold their prior values while Busy=1.
REQ-018 SHALL, on an accepted MTHI or MTLO, write DataA into HI or LO respectively at the accepting edge, leaving the other register unchanged and keeping Busy=0.
REQ-019 SHALL, on a divide by zero, produce LO = all ones and HI = DataA, and take the full DIV_CYCLES.
REQ-020 SHALL, on signed DIV of the most negative value by -1, produce LO = the most negative value and HI = 0.
REQ-021 SHALL, when Flush=1 while Busy=1, let the in-flight operation complete normally; Flush SHALL affect only a same-cycle request.
REQ-022 SHALL ignore a Start while Busy=1, including on the cycle Busy falls; the next request is accepted on the first cycle with Busy=0.
REQ-023 SHALL count the busy period with a down-counter of width clog2(max(MUL_CYCLES,DIV_CYCLES)+1); Busy SHALL equal (counter != 0).

Reset
REQ-024 SHALL, while reset=1 at an edge, drive HI=0, LO=0 and Busy=0, and clear the counter and the latched result.
REQ-025 SHALL abort an in-flight operation on reset, with no HI/LO write on the following cycle.
REQ-026 SHALL give reset priority over Start, Flush and completion.

Structure
REQ-027 SHALL take the MDctr encodings from the shared package md_pkg, next to the existing ALUctr encodings.
REQ-028 SHALL implement result computation in one combinational sub-module, md_core (WIDTH-parameterised; outputs {hi,lo} for mult/multu/div/divu), with the sequencing, counter and registers in muldiv_unit.

Verification
REQ-029 SHALL cover: WIDTH=32, MULT with DataA=0xFFFFFFFF (-1), DataB=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-030 SHALL cover: MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-031 SHALL cover: DIV -7/2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-032 SHALL cover: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 SHALL cover: MULT in flight plus Start(MTHI, 0x1234) at cycle 2 -> ignored, HI equals the product; MTLO 0x55 once Busy=0 -> LO=0x55 next cycle.
REQ-034 SHALL cover: Start with Flush=1 -> no Busy, HI/LO unchanged; reset asserted in cycle 3 of a DIV -> Busy=0, HI=LO=0, no later write.
